os_drain_ctrl: RTL
==================

OS_DRAIN_CTRL -- requirements
Module: os_drain_ctrl

Interface
REQ-001 SHALL have parameter col, default 8, number of output columns/lanes per vector.
REQ-002 SHALL have parameter psum_bw, default 16, signed width of each psum lane.
REQ-003 SHALL have parameter pmem_aw, default 9, psum memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port start  input  1  request to begin a drain of num_vec vectors.
REQ-007 SHALL have port num_vec  input  4  vectors to drain, sampled on accepted start; 0 means 8, values above 8 clamp to 8.
REQ-008 SHALL have port base_addr  input  pmem_aw  first pmem address, sampled on accepted start.
REQ-009 SHALL have port ofifo_valid  input  1  OFIFO holds at least one full vector.
REQ-010 SHALL have port ofifo_out  input  col*psum_bw  OFIFO head vector, valid while ofifo_valid=1.
REQ-011 SHALL have port ofifo_rd  output  1  pop OFIFO head at this rising edge.
REQ-012 SHALL have ports CEN_pmem, WEN_pmem  output  1 each  active-low pmem chip enable and write enable.
REQ-013 SHALL have ports A_pmem  output  pmem_aw and D_pmem  output  col*psum_bw  pmem address and write data.
REQ-014 SHALL have ports busy  output  1  drain in progress, and done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, WRITE, DONE.
REQ-016 IDLE: start=1 latches num_vec/base_addr, clears index, goes to WAIT; otherwise stays.
REQ-017 WAIT: ofifo_rd = ofifo_valid (combinational, only in WAIT); on ofifo_valid=1 capture processed ofifo_out into data register and go to WRITE; else stay.
REQ-018 WRITE: CEN_pmem=0, WEN_pmem=0, A_pmem=base+index mod 2^pmem_aw, D_pmem=data register, for exactly one cycle; increment index; go to DONE if index+1 equals count, else WAIT.
REQ-019 DONE: done=1 for one cycle, then IDLE.
REQ-020 busy SHALL be 1 in WAIT, WRITE, DONE and 0 in IDLE.
REQ-021 Outside WRITE, CEN_pmem=1, WEN_pmem=1; A_pmem and D_pmem hold last values.
REQ-022 Latency: pmem write occurs on the cycle after the ofifo_rd pop; peak throughput one vector per 2 cycles.
REQ-023 start while busy=1 SHALL be ignored, with no effect on latched parameters.
REQ-024 ofifo_rd SHALL never assert in IDLE, WRITE or DONE, even if ofifo_valid=1.
REQ-025 Address wrap: base_addr=511 with 3 vectors writes 511, 0, 1.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, index=0, ofifo_rd=0, CEN_pmem=1, WEN_pmem=1, A_pmem=0, D_pmem=0, busy=0, done=0, including mid-drain.
REQ-027 After reset release, no pmem write SHALL occur until a new start.

Configuration
REQ-028 With OS_DRAIN_RELU_EN defined, each psum_bw lane captured in WAIT SHALL be replaced by 0 when negative (MSB=1), else passed unchanged.
REQ-029 Without OS_DRAIN_RELU_EN, lanes SHALL pass through unchanged; timing is identical in both builds.

Structure
REQ-030 Shared package core_pkg SHALL hold COL, PSUM_BW, PMEM_AW constants and the drain FSM state enum type.
REQ-031 Per-lane ReLU SHALL be one sub-module, os_relu_lane, instantiated col times under OS_DRAIN_RELU_EN.

Verification
REQ-032 Reset, then start, num_vec=4, base_addr=0x010, ofifo_valid held 1 -> writes to 0x010..0x013 on alternate cycles, 4 ofifo_rd pulses, done pulses once, busy falls with done.
REQ-033 num_vec=0, ofifo_valid toggling 1-0-1 -> exactly 8 pops and 8 writes; no ofifo_rd while valid=0.
REQ-034 Lane value 0xFFF6 (-10), lane value 0x0005 -> with OS_DRAIN_RELU_EN D_pmem lanes are 0x0000 and 0x0005; without, 0xFFF6 and 0x0005.
REQ-035 base_addr=511, num_vec=3 -> A_pmem sequence 511, 0, 1.
REQ-036 reset=0 asserted in WRITE after 2 of 5 vectors -> CEN_pmem=1 and busy=0 immediately; no done pulse; next start with num_vec=1 completes normally.
REQ-037 start pulsed again during WAIT with num_vec=2 -> ignored; the original count completes.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants, drain FSM state type and count-clamp helper for the output-stationary core.
package core_pkg;

  localparam int unsigned COL     = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned PMEM_AW = 9;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StWrite,
    StDone
  } drain_state_e;

  // A request of 0 or anything above 8 drains the full 8 vectors.
  function automatic logic [3:0] clamp_count(input logic [3:0] n);
    return ((n == 4'd0) || (n > 4'd8)) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/os_relu_lane.sv
// Single-lane ReLU: negative two's-complement values become zero, others pass.
module os_relu_lane #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] i_lane,
  output logic [Width-1:0] o_lane
);

  assign o_lane = i_lane[Width-1] ? '0 : i_lane;

endmodule

// File: rtl/os_drain_ctrl.sv
// Drains OFIFO psum vectors into pmem, one write every other cycle at base+index.
// Optional per-lane ReLU on captured data when OS_DRAIN_RELU_EN is defined.
module os_drain_ctrl
  import core_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned pmem_aw = PMEM_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_vec,
  input  logic [pmem_aw-1:0]     base_addr,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   CEN_pmem,
  output logic                   WEN_pmem,
  output logic [pmem_aw-1:0]     A_pmem,
  output logic [col*psum_bw-1:0] D_pmem,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned VecW = col * psum_bw;

  drain_state_e       r_state, w_state_next;
  logic [3:0]         r_count, r_index, w_index_inc;
  logic [pmem_aw-1:0] r_base, r_addr;
  logic [VecW-1:0]    r_data, w_proc;

  assign w_index_inc = r_index + 4'd1;

`ifdef OS_DRAIN_RELU_EN
  for (genvar g = 0; g < col; g++) begin : g_relu
    os_relu_lane #(
      .Width(psum_bw)
    ) u_relu (
      .i_lane(ofifo_out[g*psum_bw +: psum_bw]),
      .o_lane(w_proc[g*psum_bw +: psum_bw])
    );
  end
`else
  assign w_proc = ofifo_out;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StWait;
      StWait:  if (ofifo_valid) w_state_next = StWrite;
      StWrite: w_state_next = (w_index_inc == r_count) ? StDone : StWait;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ofifo_rd = 1'b0;
    CEN_pmem = 1'b1;
    WEN_pmem = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (r_state)
      StIdle:  busy = 1'b0;
      StWait:  ofifo_rd = ofifo_valid;
      StWrite: begin
        CEN_pmem = 1'b0;
        WEN_pmem = 1'b0;
      end
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Address and data are registered at the pop so they hold after the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 4'd0;
      r_index <= 4'd0;
      r_base  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_count <= clamp_count(num_vec);
            r_base  <= base_addr;
            r_index <= 4'd0;
          end
        end
        StWait: begin
          if (ofifo_valid) begin
            r_data <= w_proc;
            r_addr <= r_base + pmem_aw'(r_index);
          end
        end
        StWrite: r_index <= w_index_inc;
        default: ;
      endcase
    end
  end

  assign A_pmem = r_addr;
  assign D_pmem = r_data;

endmodule
